addr_gen_bp_rw_seq: RTL and testbench
=====================================

// Module: addr_gen_bp_rw_seq
// PURPOSE
//   Parametrised read/write address sequencer for per-timestep delta buffers
//   (dout, dx, dstate) in the LSTM backprop datapath.
//   - Emits two delayed address streams (read, write) over NUM_CELL cells for every timestep.
//   - Walks timesteps forward or reversed (BPTT order) and inserts a per-timestep base offset.
//   - Optionally suppresses reads on the first timestep, pauses while en is low and pulses done at the end.
//   - Sits between fsm_bp and the delta buffer RAM ports, one instance per buffer.
// PARAMETERS
//   ADDR_WIDTH  12   width of both address outputs
//   NUM_CELL    53   cells (addresses) per timestep, >=1
//   TIMESTEP    7    timesteps per run, >=1
//   DELAY_RD    11   phase at which read stream starts within a timestep
//   DELAY_WR    9    phase at which write stream starts within a timestep
//   RD_FIRST    1    1: read on every timestep; 0: no reads on first traversed timestep
//   REVERSE     1    1: t runs TIMESTEP-1 down to 0; 0: t runs 0 up to TIMESTEP-1
//   BASE        0    address offset added to all addresses
// PORTS
//   clk         in   1           clock, rising edge
//   rst         in   1           synchronous reset, active-high
//   en          in   1           level: start from IDLE / advance while running; low = pause
//   o_addr_rd   out  ADDR_WIDTH  read address
//   o_rd_valid  out  1           o_addr_rd is valid this cycle
//   o_addr_wr   out  ADDR_WIDTH  write address
//   o_wr_valid  out  1           o_addr_wr is valid this cycle
//   o_t         out  clog2(TIMESTEP)+1  current timestep index
//   o_busy      out  1           high in RUN state
//   o_done      out  1           one-cycle pulse after final timestep completes
// BEHAVIOUR
//   - Reset (rst high at an edge): state=IDLE, phase=0, all outputs 0.
//     o_t resets to 0, or to TIMESTEP-1 when REVERSE=1. rst overrides en.
//     A reset mid-run aborts the run with no done pulse.
//   - States:
//     - IDLE -> RUN when en is sampled high (edge E0).
//     - RUN -> DONE after the last phase of the last timestep.
//     - DONE -> IDLE unconditionally (1 cycle; o_done=1 only here).
//   - Phase counter c: 0..P-1, where P = max(DELAY_RD, DELAY_WR) + NUM_CELL.
//     - c=0 in cycle C1, the cycle after E0. c increments on every edge with en=1 in RUN.
//     - en=0 in RUN freezes c, t and all address/valid outputs (valids held low while paused).
//   - Read stream: o_rd_valid=1 when DELAY_RD <= c < DELAY_RD+NUM_CELL.
//     o_addr_rd = BASE + t*NUM_CELL + (c-DELAY_RD).
//   - Write stream: identical form using DELAY_WR, with o_wr_valid/o_addr_wr.
//   - Outside a valid window, the address holds its last value.
//     Read and write windows may overlap in the same cycle; they are independent.
//   - RD_FIRST=0: o_rd_valid forced 0 for all phases of the first traversed timestep; writes unaffected.
//   - At c=P-1 with en=1: c->0 and t steps (-1 if REVERSE, else +1), no idle gap.
//     On the final timestep the state moves to DONE instead.
//   - Total run = TIMESTEP*P cycles in RUN (excluding pauses), plus 1 DONE cycle.
//   - en high in DONE or IDLE has no effect until the IDLE sample, so back-to-back runs take one IDLE gap cycle.
//   - Arithmetic: all sums are unsigned, truncated modulo 2^ADDR_WIDTH.
//     Elaboration must fail if BASE + TIMESTEP*NUM_CELL > 2^ADDR_WIDTH.
//   - Internal counters are sized with $clog2 so that P, TIMESTEP and NUM_CELL never overflow.
//   - Outputs are derived from registered state only; there is no comb path from en to any output.
// TESTING
//   Bench parameters: NUM_CELL=3, TIMESTEP=2, DELAY_RD=1, DELAY_WR=2, REVERSE=1, RD_FIRST=1, BASE=0 (P=5).
//   1 Reverse run: en held 1 from E0 ->
//     - rd 3,4,5 in C2-C4 and wr 3,4,5 in C3-C5 (t=1);
//     - rd 0,1,2 in C7-C9 and wr 0,1,2 in C8-C10 (t=0);
//     - o_done=1 in C11 only.
//   2 RD_FIRST=0, otherwise same as 1 -> no rd_valid in C1-C5; writes unchanged; reads 0,1,2 in C7-C9.
//   3 REVERSE=0, BASE=100 -> rd 100,101,102 in C2-C4, then 103,104,105 in C7-C9; o_t goes 0 then 1.
//   4 Pause: en low for 3 cycles starting C3 ->
//     - outputs frozen with valids low;
//     - sequence resumes at read addr 4, and the whole timeline shifts by 3 cycles (done in C14).
//   5 rst pulsed in C6 -> next cycle IDLE, all outputs 0, o_t=1, no o_done.
//     A subsequent en restarts from t=1, addr 3.
//   6 Overlap: DELAY_RD=DELAY_WR=0 -> rd and wr valid together in C1-C3 with equal addresses 3,4,5.

Source files
------------

// File: rtl/addr_gen_bp_rw_seq.sv
// addr_gen_bp_rw_seq: read/write address sequencer for per-timestep delta
// buffers (dout, dx, dstate) in the LSTM backprop path.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  start from IDLE / advance while running, low = pause
//   o_addr_rd/o_rd_valid  read address stream
//   o_addr_wr/o_wr_valid  write address stream
//   o_t                 current timestep index
//   o_busy, o_done      running flag, one-cycle end-of-run pulse
module addr_gen_bp_rw_seq #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NUM_CELL   = 53,
    parameter int unsigned TIMESTEP   = 7,
    parameter int unsigned DELAY_RD   = 11,
    parameter int unsigned DELAY_WR   = 9,
    parameter bit          RD_FIRST   = 1'b1,
    parameter bit          REVERSE    = 1'b1,
    parameter int unsigned BASE       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    output logic [ADDR_WIDTH-1:0]       o_addr_rd,
    output logic                        o_rd_valid,
    output logic [ADDR_WIDTH-1:0]       o_addr_wr,
    output logic                        o_wr_valid,
    output logic [$clog2(TIMESTEP):0]   o_t,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int unsigned DMAX = (DELAY_RD > DELAY_WR) ? DELAY_RD : DELAY_WR;
    localparam int unsigned P    = DMAX + NUM_CELL;
    localparam int unsigned CW   = $clog2(P + 1);
    localparam int unsigned TW   = $clog2(TIMESTEP) + 1;

    localparam logic [CW-1:0] P_LAST = CW'(P - 1);
    localparam logic [CW-1:0] RD_LO  = CW'(DELAY_RD);
    localparam logic [CW-1:0] WR_LO  = CW'(DELAY_WR);
    localparam logic [CW-1:0] NC     = CW'(NUM_CELL);

    localparam logic [TW-1:0] T_FIRST = REVERSE ? TW'(TIMESTEP - 1) : '0;
    localparam logic [TW-1:0] T_LAST  = REVERSE ? '0 : TW'(TIMESTEP - 1);

    localparam longint unsigned SPAN =
        longint'(BASE) + longint'(TIMESTEP) * longint'(NUM_CELL);

    if (SPAN > (64'd1 << ADDR_WIDTH)) begin : g_bad_span
        $error("addr_gen_bp_rw_seq: BASE + TIMESTEP*NUM_CELL exceeds address space");
    end
    if (NUM_CELL < 1 || TIMESTEP < 1) begin : g_bad_size
        $error("addr_gen_bp_rw_seq: NUM_CELL and TIMESTEP must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   c_q;
    logic [TW-1:0]   t_q;
    logic            first_q;

    // Values the counters take on the next advancing edge
    logic [CW-1:0]   c_d;
    logic [TW-1:0]   t_d;
    logic            first_d;
    logic            wrap;
    logic            last_step;
    logic [CW:0]     rd_off;
    logic [CW:0]     wr_off;
    logic            rd_hit;
    logic            wr_hit;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;

    always_comb begin
        wrap      = (c_q == P_LAST);
        last_step = wrap && (t_q == T_LAST);
        c_d       = c_q + CW'(1);
        t_d       = t_q;
        first_d   = first_q;
        if (state_q == S_IDLE) begin
            c_d     = '0;
            t_d     = T_FIRST;
            first_d = 1'b1;
        end else if (wrap) begin
            c_d     = '0;
            t_d     = REVERSE ? (t_q - TW'(1)) : (t_q + TW'(1));
            first_d = 1'b0;
        end

        // Borrow bit set means the phase is still before the window
        rd_off = {1'b0, c_d} - {1'b0, RD_LO};
        wr_off = {1'b0, c_d} - {1'b0, WR_LO};
        rd_hit = !rd_off[CW] && (rd_off[CW-1:0] < NC) && (RD_FIRST || !first_d);
        wr_hit = !wr_off[CW] && (wr_off[CW-1:0] < NC);

        row     = ADDR_WIDTH'(BASE) + ADDR_WIDTH'(32'(t_d) * NUM_CELL);
        rd_addr = row + ADDR_WIDTH'(rd_off[CW-1:0]);
        wr_addr = row + ADDR_WIDTH'(wr_off[CW-1:0]);
    end

    assign o_t = t_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            c_q        <= '0;
            t_q        <= T_FIRST;
            first_q    <= 1'b0;
            o_addr_rd  <= '0;
            o_rd_valid <= 1'b0;
            o_addr_wr  <= '0;
            o_wr_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (en) begin
                        state_q    <= S_RUN;
                        o_busy     <= 1'b1;
                        c_q        <= c_d;
                        t_q        <= t_d;
                        first_q    <= first_d;
                        o_rd_valid <= rd_hit;
                        o_wr_valid <= wr_hit;
                        if (rd_hit) o_addr_rd <= rd_addr;
                        if (wr_hit) o_addr_wr <= wr_addr;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        // Paused: counters hold, addresses hold, valids drop
                        o_rd_valid <= 1'b0;
                        o_wr_valid <= 1'b0;
                    end else if (last_step) begin
                        state_q    <= S_DONE;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_rd_valid <= 1'b0;
                        o_wr_valid <= 1'b0;
                    end else begin
                        c_q        <= c_d;
                        t_q        <= t_d;
                        first_q    <= first_d;
                        o_rd_valid <= rd_hit;
                        o_wr_valid <= wr_hit;
                        if (rd_hit) o_addr_rd <= rd_addr;
                        if (wr_hit) o_addr_wr <= wr_addr;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    o_done  <= 1'b0;
                    c_q     <= '0;
                    t_q     <= T_FIRST;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_gen_bp_rw_seq.sv
// tb_addr_gen_bp_rw_seq: scoreboard bench for addr_gen_bp_rw_seq.
// Four parameter sets share one clock; a monitor drains the expected queue.
module tb_addr_gen_bp_rw_seq;

    localparam int N = 3;
    localparam int T = 2;

    // Per-instance configuration as seen by the reference model
    int dr   [4] = '{1, 1, 1, 0};
    int dw   [4] = '{2, 2, 2, 0};
    int rdf  [4] = '{1, 0, 1, 1};
    int rev  [4] = '{1, 1, 0, 1};
    int base [4] = '{0, 0, 100, 0};

    typedef struct {
        int inst;
        int kind;
        int cyc;
        int addr;
        int t;
    } ev_t;

    ev_t q[$];

    logic        clk = 1'b0;
    logic        rst  [4];
    logic        en   [4];
    logic [11:0] ard  [4];
    logic [11:0] awr  [4];
    logic        rv   [4];
    logic        wv   [4];
    logic [1:0]  ot   [4];
    logic        busy [4];
    logic        done [4];

    int cyc   = 0;
    int nchk  = 0;
    int nfail = 0;
    bit en_pat [128];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addr_gen_bp_rw_seq #(.ADDR_WIDTH(12), .NUM_CELL(3), .TIMESTEP(2),
        .DELAY_RD(1), .DELAY_WR(2), .RD_FIRST(1'b1), .REVERSE(1'b1), .BASE(0)) u0 (
        .clk(clk), .rst(rst[0]), .en(en[0]),
        .o_addr_rd(ard[0]), .o_rd_valid(rv[0]),
        .o_addr_wr(awr[0]), .o_wr_valid(wv[0]),
        .o_t(ot[0]), .o_busy(busy[0]), .o_done(done[0]));

    addr_gen_bp_rw_seq #(.ADDR_WIDTH(12), .NUM_CELL(3), .TIMESTEP(2),
        .DELAY_RD(1), .DELAY_WR(2), .RD_FIRST(1'b0), .REVERSE(1'b1), .BASE(0)) u1 (
        .clk(clk), .rst(rst[1]), .en(en[1]),
        .o_addr_rd(ard[1]), .o_rd_valid(rv[1]),
        .o_addr_wr(awr[1]), .o_wr_valid(wv[1]),
        .o_t(ot[1]), .o_busy(busy[1]), .o_done(done[1]));

    addr_gen_bp_rw_seq #(.ADDR_WIDTH(12), .NUM_CELL(3), .TIMESTEP(2),
        .DELAY_RD(1), .DELAY_WR(2), .RD_FIRST(1'b1), .REVERSE(1'b0), .BASE(100)) u2 (
        .clk(clk), .rst(rst[2]), .en(en[2]),
        .o_addr_rd(ard[2]), .o_rd_valid(rv[2]),
        .o_addr_wr(awr[2]), .o_wr_valid(wv[2]),
        .o_t(ot[2]), .o_busy(busy[2]), .o_done(done[2]));

    addr_gen_bp_rw_seq #(.ADDR_WIDTH(12), .NUM_CELL(3), .TIMESTEP(2),
        .DELAY_RD(0), .DELAY_WR(0), .RD_FIRST(1'b1), .REVERSE(1'b1), .BASE(0)) u3 (
        .clk(clk), .rst(rst[3]), .en(en[3]),
        .o_addr_rd(ard[3]), .o_rd_valid(rv[3]),
        .o_addr_wr(awr[3]), .o_wr_valid(wv[3]),
        .o_t(ot[3]), .o_busy(busy[3]), .o_done(done[3]));

    // Monitor side: pop the head of the scoreboard for every presented output
    function automatic void chk_ev(int i, int k, int a, int tt);
        ev_t e;
        nchk++;
        if (q.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_out: inst%0d kind%0d cyc%0d addr%0d t%0d, expected none",
                     i, k, cyc, a, tt);
            return;
        end
        e = q.pop_front();
        if (e.inst != i || e.kind != k || e.cyc != cyc || e.addr != a || e.t != tt) begin
            nfail++;
            $display("FAIL event: got inst%0d kind%0d cyc%0d addr%0d t%0d, expected inst%0d kind%0d cyc%0d addr%0d t%0d",
                     i, k, cyc, a, tt, e.inst, e.kind, e.cyc, e.addr, e.t);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rv[i] === 1'b1) chk_ev(i, 0, int'(ard[i]), int'(ot[i]));
            if (wv[i] === 1'b1) chk_ev(i, 1, int'(awr[i]), int'(ot[i]));
            if (done[i] === 1'b1) chk_ev(i, 2, 0, int'(busy[i]));
        end
    end

    // Reference model: n counts active steps since start; a step maps to
    // timestep j = n / P and phase c = n % P.
    function automatic void push_cycle(int i, int cy, int n);
        int p, j, c, t;
        p = ((dr[i] > dw[i]) ? dr[i] : dw[i]) + N;
        j = n / p;
        c = n % p;
        t = (rev[i] != 0) ? (T - 1 - j) : j;
        if (c >= dr[i] && c < dr[i] + N && (rdf[i] != 0 || j != 0))
            q.push_back(ev_t'{i, 0, cy, base[i] + t * N + c - dr[i], t});
        if (c >= dw[i] && c < dw[i] + N)
            q.push_back(ev_t'{i, 1, cy, base[i] + t * N + c - dw[i], t});
    endfunction

    // Returns the last edge the stimulus must drive (done entry or reset)
    function automatic int model(int i, int s, int rst_e);
        int p, n;
        p = ((dr[i] > dw[i]) ? dr[i] : dw[i]) + N;
        n = 0;
        push_cycle(i, s, n);
        for (int e = 1; e < 127; e++) begin
            if (e == rst_e) return e;
            if (en_pat[e]) begin
                if (n == T * p - 1) begin
                    q.push_back(ev_t'{i, 2, s + e, 0, 0});
                    return e;
                end
                n++;
                push_cycle(i, s + e, n);
            end
        end
        return 127;
    endfunction

    function automatic void fill_pat(int pe, int plen);
        for (int e = 0; e < 128; e++)
            en_pat[e] = !(e >= pe && e < pe + plen);
    endfunction

    function automatic void fill_rand();
        for (int e = 0; e < 128; e++)
            en_pat[e] = (e >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
    endfunction

    function automatic void chk_idle(int i, string nm);
        int et;
        et = (rev[i] != 0) ? (T - 1) : 0;
        nchk++;
        if (rv[i] !== 1'b0 || wv[i] !== 1'b0 || busy[i] !== 1'b0 || done[i] !== 1'b0 ||
            ard[i] !== 12'd0 || awr[i] !== 12'd0 || int'(ot[i]) != et) begin
            nfail++;
            $display("FAIL %s inst%0d: got rv%b wv%b busy%b done%b ard%0d awr%0d t%0d, expected zeros t%0d",
                     nm, i, rv[i], wv[i], busy[i], done[i], ard[i], awr[i], ot[i], et);
        end
    endfunction

    task automatic do_run(input int i, input int rst_e);
        int s, last;
        @(negedge clk);
        s = cyc + 1;
        last = model(i, s, rst_e);
        en[i] = 1'b1;
        for (int e = 1; e <= last; e++) begin
            @(negedge clk);
            en[i]  = en_pat[e];
            rst[i] = (e == rst_e);
        end
        @(negedge clk);
        en[i]  = 1'b0;
        rst[i] = 1'b0;
        if (rst_e > 0) chk_idle(i, "after_reset");
        repeat (3) @(negedge clk);
        @(posedge clk);
        nchk++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL missing_out inst%0d: %0d expected events left, required 0", i, q.size());
            q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b0;
        end
        en[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_idle(i, "reset_state");
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b0;
            en[i]  = 1'b0;
        end
        repeat (2) @(negedge clk);

        fill_pat(0, 0);
        do_run(0, 0);
        do_run(1, 0);
        do_run(2, 0);
        fill_pat(2, 3);
        do_run(0, 0);
        fill_pat(0, 0);
        do_run(0, 6);
        do_run(0, 0);
        do_run(3, 0);

        for (int r = 0; r < 12; r++) begin
            fill_rand();
            do_run($urandom_range(0, 3), (r % 4 == 3) ? $urandom_range(1, 9) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
